// File: rtl/prog_fetch_pkg.sv
// Shared constants, FSM state type and lane address helper for the program fetch unit.
package prog_fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 256;
  localparam int FETCH_N_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] idx;
    logic        in_range;
  } lane_t;

  // Lane k of a fetch at base; the 32-bit sum never truncates base+k.
  function automatic lane_t lane_addr(input logic [31:0] base, input int k,
                                      input logic wrap, input int depth);
    lane_t       r;
    logic [31:0] a;
    a          = base + k;
    r.in_range = (a < depth);
    if (r.in_range)
      r.idx = a;
    else if (wrap)
      r.idx = a % depth;
    else
      r.idx = '0;
    return r;
  endfunction

endpackage

// File: rtl/prog_fetch_bank.sv
// Program storage: one write port, FETCH_N combinational read lanes (optional oob flag under FETCH_OOB_ERR_EN).
// Latency: writes land on the clock edge, reads are combinational.
// Backpressure: none; the caller keeps writes and fetches in separate cycles.
module prog_fetch_bank
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int FETCH_N = FETCH_N_DEF,
  parameter int WRAP    = 0
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [FETCH_N*DATA_W-1:0] rdata
`ifdef FETCH_OOB_ERR_EN
  ,output logic                     oob
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  lane_t             lane;

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH))
      mem[IDX_W'(waddr)] <= wdata;
  end

  always_comb begin
    rdata = '0;
    lane  = '0;
`ifdef FETCH_OOB_ERR_EN
    oob   = 1'b0;
`endif
    for (int k = 0; k < FETCH_N; k++) begin
      lane = lane_addr(32'(raddr), k, WRAP != 0, DEPTH);
      // Out-of-range lanes without wrap stay zero.
      if (lane.in_range || (WRAP != 0))
        rdata[k*DATA_W +: DATA_W] = mem[IDX_W'(lane.idx)];
`ifdef FETCH_OOB_ERR_EN
      if (!lane.in_range)
        oob = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/prog_fetch_mem.sv
// Program memory with valid/ready instruction fetch; rsp_err added under FETCH_OOB_ERR_EN.
// Latency: response registered exactly 1 cycle after request acceptance.
// Backpressure: response held frozen while rsp_ready=0; req_ready drops on stall or load.
module prog_fetch_mem
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int FETCH_N = FETCH_N_DEF,
  parameter int WRAP    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_en,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ADDR_W-1:0]         rsp_addr,
  output logic [FETCH_N*DATA_W-1:0] rsp_data
`ifdef FETCH_OOB_ERR_EN
  ,output logic                     rsp_err
`endif
);

  fetch_state_e              state, state_nxt;
  logic                      accept;
  logic [FETCH_N*DATA_W-1:0] rd_data;
`ifdef FETCH_OOB_ERR_EN
  logic                      rd_oob;
`endif

  prog_fetch_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .FETCH_N(FETCH_N),
    .WRAP   (WRAP)
  ) u_bank (
    .clk  (clk),
    .we   (load_en && !reset),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(req_addr),
    .rdata(rd_data)
`ifdef FETCH_OOB_ERR_EN
    ,.oob (rd_oob)
`endif
  );

  assign rsp_valid = (state == HOLD);
  // A load cycle never overlaps a fetch read.
  assign req_ready = !load_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (rsp_ready && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rsp_addr <= '0;
      rsp_data <= '0;
`ifdef FETCH_OOB_ERR_EN
      rsp_err  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_addr <= req_addr;
        rsp_data <= rd_data;
`ifdef FETCH_OOB_ERR_EN
        rsp_err  <= rd_oob;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_fetch_mem.sv
// Directed bench for prog_fetch_mem: a WRAP=0 and a WRAP=1 instance share all inputs.
module tb_prog_fetch_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic        rsp_ready;
  logic        req_ready0, req_ready1;
  logic        rsp_valid0, rsp_valid1;
  logic [7:0]  rsp_addr0, rsp_addr1;
  logic [15:0] rsp_data0, rsp_data1;
`ifdef FETCH_OOB_ERR_EN
  logic        rsp_err0, rsp_err1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_fetch_mem #(.WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr0), .rsp_data(rsp_data0)
`ifdef FETCH_OOB_ERR_EN
    , .rsp_err(rsp_err0)
`endif
  );

  prog_fetch_mem #(.WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr1), .rsp_data(rsp_data1)
`ifdef FETCH_OOB_ERR_EN
    , .rsp_err(rsp_err1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  logic [15:0] stream_exp [4];

  initial begin
    stream_exp[0] = 16'h0310;
    stream_exp[1] = 16'h3322;
    stream_exp[2] = 16'h5544;
    stream_exp[3] = 16'h7766;

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    tick();
    tick();
    check("reset_valid0", 64'(rsp_valid0), 64'd0);
    check("reset_valid1", 64'(rsp_valid1), 64'd0);
    check("reset_addr",   64'(rsp_addr0),  64'd0);
    check("reset_data",   64'(rsp_data0),  64'd0);
`ifdef FETCH_OOB_ERR_EN
    check("reset_err",    64'(rsp_err0),   64'd0);
`endif
    reset = 1'b0;

    load(8'd0, 8'h10);
    load(8'd1, 8'h03);
    load(8'd2, 8'h22);
    load(8'd3, 8'h33);
    load(8'd4, 8'h44);
    load(8'd5, 8'h55);
    load(8'd6, 8'h66);
    load(8'd7, 8'h77);
    load(8'd255, 8'hAA);

    // Basic fetch of address 0
    req_valid = 1'b1; req_addr = 8'd0;
    #1 check("t1_req_ready", 64'(req_ready0), 64'd1);
    tick();
    check("t1_valid", 64'(rsp_valid0), 64'd1);
    check("t1_data0", 64'(rsp_data0),  64'h0310);
    check("t1_data1", 64'(rsp_data1),  64'h0310);
    check("t1_addr",  64'(rsp_addr0),  64'd0);

    // Back-to-back fetch at the top of memory
    req_addr = 8'd255;
    #1 check("t2_req_ready", 64'(req_ready0), 64'd1);
    tick();
    check("t2_data_nowrap", 64'(rsp_data0), 64'h00AA);
    check("t2_data_wrap",   64'(rsp_data1), 64'h10AA);
    check("t2_addr",        64'(rsp_addr0), 64'hFF);
`ifdef FETCH_OOB_ERR_EN
    check("t2_err_nowrap",  64'(rsp_err0),  64'd1);
    check("t2_err_wrap",    64'(rsp_err1),  64'd1);
`endif

    // Consumer stall for three cycles
    rsp_ready = 1'b0; req_addr = 8'd2;
    #1 check("t3_req_ready_stall", 64'(req_ready0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", 64'(rsp_valid0), 64'd1);
      check("t3_hold_data",  64'(rsp_data0),  64'h00AA);
      check("t3_hold_addr",  64'(rsp_addr0),  64'hFF);
      check("t3_hold_ready", 64'(req_ready0), 64'd0);
    end
    rsp_ready = 1'b1;
    #1 check("t3_req_ready_release", 64'(req_ready0), 64'd1);
    tick();
    check("t3_after_data", 64'(rsp_data0), 64'h3322);
    check("t3_after_addr", 64'(rsp_addr0), 64'd2);

    // Streaming one fetch per cycle
    for (int i = 0; i < 4; i++) begin
      req_addr = 8'(2 * i);
      tick();
      check("t4_valid", 64'(rsp_valid0), 64'd1);
      check("t4_addr",  64'(rsp_addr0),  64'(2 * i));
      check("t4_data",  64'(rsp_data0),  64'(stream_exp[i]));
    end
    req_valid = 1'b0;
    tick();
    check("t4_idle", 64'(rsp_valid0), 64'd0);

    // Load and request in the same cycle: load wins, fetch follows
    load_en = 1'b1; load_addr = 8'd8; load_data = 8'h88;
    req_valid = 1'b1; req_addr = 8'd7;
    #1 check("t5_req_ready_load", 64'(req_ready0), 64'd0);
    tick();
    check("t5_no_rsp", 64'(rsp_valid0), 64'd0);
    load_en = 1'b0;
    #1 check("t5_req_ready_after", 64'(req_ready0), 64'd1);
    tick();
    req_valid = 1'b0;
    check("t5_valid", 64'(rsp_valid0), 64'd1);
    check("t5_data",  64'(rsp_data0),  64'h8877);
    check("t5_addr",  64'(rsp_addr0),  64'd7);

    // Load during HOLD leaves the held response untouched
    rsp_ready = 1'b0;
    load(8'd7, 8'h99);
    check("t5_snapshot", 64'(rsp_data0), 64'h8877);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'd7;
    tick();
    req_valid = 1'b0;
    check("t5_reload_data", 64'(rsp_data0), 64'h8899);

    // Reset in HOLD drops the response; a load under reset is ignored
    rsp_ready = 1'b0; reset = 1'b1;
    load_en = 1'b1; load_addr = 8'd0; load_data = 8'hEE;
    tick();
    check("t6_rst_valid", 64'(rsp_valid0), 64'd0);
    check("t6_rst_data",  64'(rsp_data0),  64'd0);
    check("t6_rst_addr",  64'(rsp_addr0),  64'd0);
    reset = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd0;
    tick();
    req_valid = 1'b0;
    check("t6_retained_valid", 64'(rsp_valid0), 64'd1);
    check("t6_retained_data",  64'(rsp_data0),  64'h0310);
    tick();
    check("t6_final_idle", 64'(rsp_valid0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_fetch_mem.md
Name: prog_fetch_mem

Overview:
- Parametrised, clocked program memory and instruction-fetch unit for the CPU.
- Each accepted request returns FETCH_N consecutive memory words starting at the request address. With the defaults this is an opcode byte plus its operand byte.
- Reads are registered, with a valid/ready handshake on both the request and response sides.
- A write port loads the program before or between runs. Memory contents survive reset.

Parameters:
- ADDR_W, 8: request/load address width.
- DATA_W, 8: memory word width.
- DEPTH, 256: number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- FETCH_N, 2: words returned per fetch; range 1..4.
- WRAP, 0: 0 = lanes beyond DEPTH-1 read as zero; 1 = lane addresses wrap modulo DEPTH.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- load_en, in, 1: write mem[load_addr] = load_data this edge.
- load_addr, in, ADDR_W: load address.
- load_data, in, DATA_W: load word.
- req_valid, in, 1: fetch request present.
- req_ready, out, 1: fetch request can be accepted this cycle.
- req_addr, in, ADDR_W: fetch start address.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer takes the response.
- rsp_addr, out, ADDR_W: start address of the current response.
- rsp_data, out, FETCH_N*DATA_W: lane k at bits [k*DATA_W +: DATA_W] holds word addr+k.

Behaviour:
- Reset:
  - rsp_valid=0, rsp_addr=0, rsp_data=0, state IDLE.
  - Memory array is not cleared.
  - load_en is ignored while reset=1.
- req_ready is combinational: = !load_en && (!rsp_valid || rsp_ready). A load cycle always stalls fetch, so there is no read/write collision.
- A request is accepted when req_valid && req_ready.
  - Next edge: rsp_valid=1, rsp_addr=req_addr, rsp_data loaded from memory.
  - Latency is exactly 1 cycle.
- State machine:
  - IDLE (rsp_valid=0): accept -> HOLD.
  - HOLD (rsp_valid=1):
    - rsp_ready && accept -> HOLD with new data (back-to-back, 1 fetch/cycle).
    - rsp_ready && no accept -> IDLE.
    - !rsp_ready -> HOLD with rsp_data and rsp_addr frozen.
- Lane address for lane k is a = req_addr + k, computed at ADDR_W+2 bits (no truncation).
  - a < DEPTH: lane = mem[a].
  - a >= DEPTH, WRAP=0: lane = 0.
  - a >= DEPTH, WRAP=1: lane = mem[a mod DEPTH].
  - A req_addr >= DEPTH follows the same rule for every lane.
- Load:
  - load_addr >= DEPTH: write ignored.
  - A load at edge t is visible to any fetch accepted at edge t+1 or later.
- Load while in HOLD: the held response keeps the old data (snapshot semantics).
- Reset asserted in HOLD: the pending response is dropped and rsp_valid=0 after that edge. The consumer must not count it.
- X on req_addr is irrelevant while req_valid=0. Outputs never propagate X after reset.

Optional Feature:
- Macro: FETCH_OOB_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit), registered alongside rsp_data.
  - rsp_err = 1 iff any lane address a >= DEPTH, regardless of WRAP.
  - Reset value 0; frozen in HOLD like the other response fields.
- Undefined: the port does not exist and there is no related logic.

Decomposition:
- Package prog_fetch_pkg:
  - default constants for ADDR_W, DATA_W, DEPTH, FETCH_N.
  - enum fetch_state_e {IDLE, HOLD}.
  - a function lane_addr(base, k, wrap) returning the index plus an in-range flag.
- Sub-module prog_fetch_bank:
  - storage array, one write port, FETCH_N combinational read lanes, WRAP/zero handling.
- Top level: handshake FSM and response registers.

Test Plan (DEPTH=256, FETCH_N=2 unless noted):
- Load mem[0]=0x10, mem[1]=0x03; request addr 0 -> one cycle later rsp_valid=1, rsp_data=0x0310, rsp_addr=0.
- Load mem[255]=0xAA, mem[0]=0x10; request 255 with WRAP=0 -> rsp_data=0x00AA (rsp_err=1 if enabled). With WRAP=1 -> 0x10AA.
- Hold rsp_ready=0 for 3 cycles after a response -> rsp_data/rsp_addr stable, req_ready=0. Release -> next accepted request completes 1 cycle later.
- Streaming requests 0, 2, 4, 6 with rsp_ready=1 -> four responses on four consecutive cycles, data matching each pair.
- load_en=1 with req_valid=1 in the same cycle -> req_ready=0 and no response. Next cycle the request is accepted and returns the newly loaded word.
- Reset pulsed during HOLD -> rsp_valid=0 after that edge. Refetch of addr 0 still returns 0x0310, showing memory is retained.
